// File: rtl/vm_pkg.sv
// Shared constants and types for the vending machine: coin encodings, unit values, FSM states.
// The optional change feature is selected with the VM_CHANGE_EN macro (see vending_machine_param.sv).
package vm_pkg;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam int UNIT_W        = 3;
    localparam int QUARTER_UNITS = 5;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_CHANGE  = 2'd2
    } vm_state_t;

endpackage

// File: rtl/vending_machine_param_if.sv
// Coin/cancel inputs and vend/change/busy/credit outputs of the vending machine.
interface vending_machine_param_if #(
    parameter int CREDIT_W = 4
);
    logic [1:0]          coin;
    logic                cancel;
    logic                vend;
    logic                change_out;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (output coin, cancel, input vend, change_out, busy, credit);
    modport slave  (input coin, cancel, output vend, change_out, busy, credit);
endinterface

// File: rtl/vm_coin_decode.sv
// Combinational map from the 2-bit coin code to its value in 5-cent units.
module vm_coin_decode
    import vm_pkg::*;
(
    input  logic [1:0]        i_coin,
    output logic [UNIT_W-1:0] o_units
);

    always_comb begin
        o_units = '0;
        case (i_coin)
            COIN_NICKEL:  o_units = UNIT_W'(1);
            COIN_DIME:    o_units = UNIT_W'(2);
            COIN_QUARTER: o_units = UNIT_W'(QUARTER_UNITS);
            default:      o_units = '0;
        endcase
    end

endmodule

// File: rtl/vending_machine_param.sv
// Parameterised coin-operated vending machine (Moore FSM, registered outputs).
// Define VM_CHANGE_EN to return overpayment and cancelled credit as nickel pulses.
//
//  state      | meaning
//  ST_COLLECT | accepting coins and cancel, busy low
//  ST_VEND    | one-cycle dispense pulse, price deducted on exit
//  ST_CHANGE  | one change_out pulse per remaining unit of credit
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4
) (
    input logic                    clk,
    input logic                    rst,
    vending_machine_param_if.slave bus
);

    // Worst case in COLLECT is (PRICE-1) plus a quarter, so this bound rules out wrap.
    generate
        if (PRICE < 1 || PRICE > 31 || (PRICE + QUARTER_UNITS - 1) >= (2 ** CREDIT_W)) begin : g_param_err
            $error("vending_machine_param: PRICE/CREDIT_W combination would overflow credit");
        end
    endgenerate

    localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] LP_ONE   = CREDIT_W'(1);

    vm_state_t           r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_vend;
    logic                r_change;
    logic                r_busy;

    logic [UNIT_W-1:0]   w_units;
    logic [CREDIT_W-1:0] w_sum;

    vm_coin_decode u_coin_decode (
        .i_coin  (bus.coin),
        .o_units (w_units)
    );

    assign w_sum = r_credit + CREDIT_W'(w_units);

`ifdef VM_CHANGE_EN
    logic [CREDIT_W-1:0] w_rem;
    assign w_rem = r_credit - LP_PRICE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_COLLECT;
            r_credit <= '0;
            r_vend   <= 1'b0;
            r_change <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    // Cancel refunds the coin-inclusive total and takes priority over a vend.
                    if (bus.cancel && (w_sum != '0)) begin
`ifdef VM_CHANGE_EN
                        r_state  <= ST_CHANGE;
                        r_credit <= w_sum;
                        r_change <= 1'b1;
                        r_busy   <= 1'b1;
`else
                        r_credit <= '0;
`endif
                    end else if (w_sum >= LP_PRICE) begin
                        r_state  <= ST_VEND;
                        r_credit <= w_sum;
                        r_vend   <= 1'b1;
                        r_busy   <= 1'b1;
                    end else begin
                        r_credit <= w_sum;
                    end
                end
                ST_VEND: begin
                    r_vend <= 1'b0;
`ifdef VM_CHANGE_EN
                    r_credit <= w_rem;
                    if (w_rem != '0) begin
                        r_state  <= ST_CHANGE;
                        r_change <= 1'b1;
                    end else begin
                        r_state <= ST_COLLECT;
                        r_busy  <= 1'b0;
                    end
`else
                    r_credit <= '0;
                    r_state  <= ST_COLLECT;
                    r_busy   <= 1'b0;
`endif
                end
                ST_CHANGE: begin
                    r_credit <= r_credit - LP_ONE;
                    if (r_credit == LP_ONE) begin
                        r_state  <= ST_COLLECT;
                        r_change <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_COLLECT;
                    r_credit <= '0;
                    r_vend   <= 1'b0;
                    r_change <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vend       = r_vend;
    assign bus.change_out = r_change;
    assign bus.busy       = r_busy;
    assign bus.credit     = r_credit;

endmodule
